pwm_sample_decoder: RTL and testbench



---
 rtl/pwm_sample_decoder.sv | 137 +++++++++++++
 tb/tb_pwm_sample_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sample_decoder.sv
// rtl/pwm_sample_decoder.sv - recovers the PWM duty value per frame from an asynchronous PWM bitstream
module pwm_sample_decoder #(
   parameter int PERIOD   = 256,
   parameter int TOL      = 0,
   parameter int SAMPLE_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pwm_in,
   output logic [SAMPLE_W-1:0] sample,
   output logic                sample_valid,
   output logic                frame_error,
   output logic                stuck
);

   // A frame longer than this without a rising edge means the input is stuck at a level.
   localparam int LIMIT = PERIOD + TOL + 1;
   localparam int CW    = $clog2(LIMIT) + 1;
   localparam int SW    = $clog2(PERIOD + 1);
   localparam int LO_P  = (TOL >= PERIOD) ? 0 : PERIOD - TOL;
   localparam int HI_P  = PERIOD + TOL;
   localparam int SMAX  = (2 ** SAMPLE_W) - 1;
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   typedef enum logic [1:0] {ACQUIRE, TRACK, STUCK} state_t;

   state_t              state_q;
   logic                s1_q, pwm_s_q, pwm_d_q;
   logic [CW-1:0]       cyc_cnt_q, cyc_cnt_d;
   logic [CW-1:0]       hi_cnt_q, hi_cnt_d;
   logic [SW-1:0]       stk_cnt_q;
   logic [SAMPLE_W-1:0] sample_q;
   logic                valid_q, err_q, stuck_q;

   logic                rise;
   logic                frame_ok;
   logic [SAMPLE_W-1:0] sat_h;
   logic [SAMPLE_W-1:0] level;

   assign rise     = pwm_s_q & ~pwm_d_q;
   // The measured frame is the counter value in the rise cycle, before it reloads.
   assign frame_ok = (cyc_cnt_q >= CW'(LO_P)) && (cyc_cnt_q <= CW'(HI_P));
   assign sat_h    = (hi_cnt_q > CW'(SMAX)) ? {SAMPLE_W{1'b1}} : SAMPLE_W'(hi_cnt_q);
   assign level    = {SAMPLE_W{pwm_s_q}};

   // Two-flop synchronizer plus one delay flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         pwm_s_q <= 1'b0;
         pwm_d_q <= 1'b0;
      end else begin
         s1_q    <= pwm_in;
         pwm_s_q <= s1_q;
         pwm_d_q <= pwm_s_q;
      end
   end

   // Saturating frame-length and high-time counters; the rise cycle opens the new frame.
   always_comb begin
      cyc_cnt_d = cyc_cnt_q;
      hi_cnt_d  = hi_cnt_q;
      if (rise) begin
         cyc_cnt_d = CW'(1);
         hi_cnt_d  = CW'(1);
      end else begin
         if (cyc_cnt_q != CNT_MAX) cyc_cnt_d = cyc_cnt_q + CW'(1);
         if (hi_cnt_q != CNT_MAX)  hi_cnt_d  = hi_cnt_q + CW'(pwm_s_q);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt_q <= '0;
         hi_cnt_q  <= '0;
      end else begin
         cyc_cnt_q <= cyc_cnt_d;
         hi_cnt_q  <= hi_cnt_d;
      end
   end

   // Frame tracking FSM with registered strobes; a rise always wins over a timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACQUIRE;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         stuck_q   <= 1'b0;
         stk_cnt_q <= '0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ACQUIRE, TRACK: begin
               if (rise) begin
                  state_q <= TRACK;
                  if (state_q == TRACK) begin
                     if (frame_ok) begin
                        sample_q <= sat_h;
                        valid_q  <= 1'b1;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end else if (cyc_cnt_q >= CW'(LIMIT)) begin
                  state_q   <= STUCK;
                  sample_q  <= level;
                  valid_q   <= 1'b1;
                  stuck_q   <= 1'b1;
                  stk_cnt_q <= SW'(1);
               end
            end
            STUCK: begin
               if (rise) begin
                  state_q <= TRACK;
                  stuck_q <= 1'b0;
               end else if (stk_cnt_q == SW'(PERIOD)) begin
                  sample_q  <= level;
                  valid_q   <= 1'b1;
                  stk_cnt_q <= SW'(1);
               end else begin
                  stk_cnt_q <= stk_cnt_q + SW'(1);
               end
            end
            default: state_q <= ACQUIRE;
         endcase
      end
   end

   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign frame_error  = err_q;
   assign stuck        = stuck_q;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// tb/tb_pwm_sample_decoder.sv - self-checking bench for pwm_sample_decoder against an event-level model
module tb_pwm_sample_decoder;

   localparam int MAXN   = 3200;
   localparam int PERIOD = 256;

   logic       clk;
   logic       rst_n;
   logic       pwm_in;
   logic [7:0] sample0, sample8;
   logic       valid0, valid8, err0, err8, stuck0, stuck8;

   int checks;
   int failures;

   int v [MAXN];
   int m_valid [2][MAXN];
   int m_err   [2][MAXN];
   int m_smp   [2][MAXN];
   int m_stk   [2][MAXN];

   pwm_sample_decoder #(.PERIOD(256), .TOL(0), .SAMPLE_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
      .sample(sample0), .sample_valid(valid0), .frame_error(err0), .stuck(stuck0)
   );

   pwm_sample_decoder #(.PERIOD(256), .TOL(8), .SAMPLE_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
      .sample(sample8), .sample_valid(valid8), .frame_error(err8), .stuck(stuck8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, obs, exp);
      end
   endtask

   task automatic clear_wave();
      for (int i = 0; i < MAXN; i++) v[i] = 0;
   endtask

   task automatic add_frame(input int start, input int high);
      for (int j = 0; j < high; j++) if (start + j < MAXN) v[start + j] = 1;
   endtask

   // Expected outputs derived from the rising edges of the driven waveform:
   // an edge driven in cycle r is reported in cycle r+3, reset acts as a silent edge at -3.
   task automatic build_model(input int k, input int tol, input int n);
      int rises[$];
      int sev  [MAXN];
      int stev [MAXN];
      int lim, ref_c, mode, r, p, h, cur_s, cur_k, t0;
      lim = PERIOD + tol + 1;
      for (int c = 0; c < n; c++) begin
         m_valid[k][c] = 0;
         m_err[k][c]   = 0;
         sev[c]        = -1;
         stev[c]       = -1;
      end
      for (int c = 0; c < n; c++)
         if (v[c] == 1 && (c == 0 || v[c-1] == 0)) rises.push_back(c);
      rises.push_back(n + lim + PERIOD);
      ref_c = -3;
      mode  = 0;
      for (int i = 0; i < rises.size(); i++) begin
         r = rises[i];
         if (mode != 2 && r - ref_c > lim) begin
            mode = 2;
            t0   = ref_c + 3 + lim;
            for (int t = t0; t < r + 3 && t < n; t += PERIOD) begin
               m_valid[k][t] = 1;
               sev[t] = (v[t-3] == 1) ? 255 : 0;
               if (t == t0) stev[t] = 1;
            end
         end
         if (i == rises.size() - 1) break;
         if (mode == 2) begin
            if (r + 3 < n) stev[r+3] = 0;
            mode = 1;
         end else if (mode == 0) begin
            mode = 1;
         end else begin
            p = r - ref_c;
            h = 0;
            for (int j = ref_c; j < r; j++) h += v[j];
            if (r + 3 < n) begin
               if (p >= PERIOD - tol && p <= PERIOD + tol) begin
                  m_valid[k][r+3] = 1;
                  sev[r+3] = (h > 255) ? 255 : h;
               end else begin
                  m_err[k][r+3] = 1;
               end
            end
         end
         ref_c = r;
      end
      cur_s = 0;
      cur_k = 0;
      for (int c = 0; c < n; c++) begin
         if (sev[c] >= 0)  cur_s = sev[c];
         if (stev[c] >= 0) cur_k = stev[c];
         m_smp[k][c] = cur_s;
         m_stk[k][c] = cur_k;
      end
   endtask

   task automatic do_reset(input string name);
      @(posedge clk);
      #1 rst_n = 1'b0;
      pwm_in = 1'b0;
      #1;
      chk({name, "/rst sample0"}, -1, 32'(sample0), 0);
      chk({name, "/rst valid0"},  -1, 32'(valid0),  0);
      chk({name, "/rst err0"},    -1, 32'(err0),    0);
      chk({name, "/rst stuck0"},  -1, 32'(stuck0),  0);
      chk({name, "/rst sample8"}, -1, 32'(sample8), 0);
      chk({name, "/rst valid8"},  -1, 32'(valid8),  0);
      chk({name, "/rst err8"},    -1, 32'(err8),    0);
      chk({name, "/rst stuck8"},  -1, 32'(stuck8),  0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_seg(input string name, input int n);
      build_model(0, 0, n);
      build_model(1, 8, n);
      do_reset(name);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1 pwm_in = v[c][0];
         @(negedge clk);
         chk({name, "/valid t0"},  c, 32'(valid0),  m_valid[0][c]);
         chk({name, "/err t0"},    c, 32'(err0),    m_err[0][c]);
         chk({name, "/sample t0"}, c, 32'(sample0), m_smp[0][c]);
         chk({name, "/stuck t0"},  c, 32'(stuck0),  m_stk[0][c]);
         chk({name, "/valid t8"},  c, 32'(valid8),  m_valid[1][c]);
         chk({name, "/err t8"},    c, 32'(err8),    m_err[1][c]);
         chk({name, "/sample t8"}, c, 32'(sample8), m_smp[1][c]);
         chk({name, "/stuck t8"},  c, 32'(stuck8),  m_stk[1][c]);
      end
   endtask

   initial begin
      int pos, per, hi;
      int duties [5];
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      pwm_in   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 25% duty, five frames, then idle low into the stuck detector.
      clear_wave();
      pos = 10;
      for (int i = 0; i < 5; i++) begin add_frame(pos, 64); pos += 256; end
      run_seg("duty64", pos + 300);

      // Duty 1, 128, 255.
      clear_wave();
      duties = '{1, 1, 128, 255, 40};
      pos = 5;
      for (int i = 0; i < 5; i++) begin add_frame(pos, duties[i]); pos += 256; end
      run_seg("duties", pos + 10);

      // Held low, then a stream resumes.
      clear_wave();
      pos = 800;
      for (int i = 0; i < 3; i++) begin add_frame(pos, 100); pos += 256; end
      run_seg("hold0", pos + 10);

      // Held high, then a 50% stream.
      clear_wave();
      add_frame(0, 700);
      pos = 760;
      for (int i = 0; i < 4; i++) begin add_frame(pos, 128); pos += 256; end
      run_seg("hold1", pos + 10);

      // 250-cycle frames: error at TOL=0, valid at TOL=8.
      clear_wave();
      pos = 7;
      for (int i = 0; i < 6; i++) begin add_frame(pos, 100); pos += 250; end
      run_seg("per250", pos + 10);

      // Randomized frame lengths and duties, with one over-long frame.
      clear_wave();
      pos = 3;
      for (int i = 0; i < 10; i++) begin
         per = (i == 6) ? 300 : int'($urandom_range(268, 244));
         hi  = int'($urandom_range(per - 1, 1));
         add_frame(pos, hi);
         pos += per;
      end
      run_seg("random", pos + 10);

      // Stream stopped mid-frame, then reset asserted with sample holding 64.
      clear_wave();
      pos = 10;
      for (int i = 0; i < 4; i++) begin add_frame(pos, 64); pos += 256; end
      run_seg("prereset", 10 + 3 * 256 + 100);

      // After the mid-frame reset, the first edge only acquires.
      clear_wave();
      pos = 156;
      for (int i = 0; i < 3; i++) begin add_frame(pos, 64); pos += 256; end
      run_seg("postreset", pos + 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
